// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MIPS memory-access stage: aluop codes,
// FSM encoding, exception bit positions, bus size codes and the MEM/WB record.
package mem_stage_pkg;

   localparam logic [7:0] ALUOP_ADDU = 8'b0010_0001;
   localparam logic [7:0] ALUOP_LB   = 8'b1110_0000;
   localparam logic [7:0] ALUOP_LBU  = 8'b1110_0100;
   localparam logic [7:0] ALUOP_LH   = 8'b1110_0001;
   localparam logic [7:0] ALUOP_LHU  = 8'b1110_0101;
   localparam logic [7:0] ALUOP_LW   = 8'b1110_0011;
   localparam logic [7:0] ALUOP_SB   = 8'b1110_1000;
   localparam logic [7:0] ALUOP_SH   = 8'b1110_1001;
   localparam logic [7:0] ALUOP_SW   = 8'b1110_1011;

   typedef enum logic [1:0] {
      MEM_IDLE  = 2'd0,
      MEM_ADDR  = 2'd1,
      MEM_DATA  = 2'd2,
      MEM_DRAIN = 2'd3
   } mem_state_e;

   localparam int EXC_ADEL = 28;
   localparam int EXC_ADES = 27;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [7:0]  aluop;
      logic        in_dslot;
      logic [31:0] exc;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
      logic        hi_we;
      logic [31:0] hi_wdata;
      logic        lo_we;
      logic [31:0] lo_wdata;
      logic        cp0_we;
      logic [4:0]  cp0_waddr;
      logic [31:0] cp0_wdata;
      logic [31:0] bad_vaddr;
   } wb_t;

   function automatic logic is_load(input logic [7:0] op);
      return op inside {ALUOP_LB, ALUOP_LBU, ALUOP_LH, ALUOP_LHU, ALUOP_LW};
   endfunction

   function automatic logic is_store(input logic [7:0] op);
      return op inside {ALUOP_SB, ALUOP_SH, ALUOP_SW};
   endfunction

   function automatic logic misaligned(input logic [7:0] op, input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      if (op inside {ALUOP_LH, ALUOP_LHU, ALUOP_SH}) bad = lo[0];
      else if (op inside {ALUOP_LW, ALUOP_SW})     bad = (lo != 2'b00);
      return bad;
   endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational data-path of the memory stage: extracts and extends load data,
// and builds byte strobes / replicated write data for stores.
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [7:0]  aluop_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] load_data_o,
   output logic [31:0] wdata_o,
   output logic [3:0]  wstrb_o,
   output logic [1:0]  size_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel    = rdata_i[{addr_lo_i, 3'b000} +: 8];
      half_sel    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      load_data_o = rdata_i;
      wdata_o     = store_data_i;
      wstrb_o     = 4'b0000;
      size_o      = SIZE_WORD;
      case (aluop_i)
         ALUOP_LB: begin
            load_data_o = {{24{byte_sel[7]}}, byte_sel};
            size_o      = SIZE_BYTE;
         end
         ALUOP_LBU: begin
            load_data_o = {24'h000000, byte_sel};
            size_o      = SIZE_BYTE;
         end
         ALUOP_LH: begin
            load_data_o = {{16{half_sel[15]}}, half_sel};
            size_o      = SIZE_HALF;
         end
         ALUOP_LHU: begin
            load_data_o = {16'h0000, half_sel};
            size_o      = SIZE_HALF;
         end
         ALUOP_SB: begin
            wstrb_o = 4'b0001 << addr_lo_i;
            wdata_o = {4{store_data_i[7:0]}};
            size_o  = SIZE_BYTE;
         end
         ALUOP_SH: begin
            wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{store_data_i[15:0]}};
            size_o  = SIZE_HALF;
         end
         ALUOP_SW: wstrb_o = 4'b1111;
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: issues SRAM-like bus transactions for loads/stores,
// raises address errors, stalls while a transaction is outstanding, feeds MEM/WB.
//
//   state     | meaning
//   MEM_IDLE  | no transaction outstanding; memory op issues req this cycle
//   MEM_ADDR  | req held, waiting for addr_ok
//   MEM_DATA  | request accepted, waiting for data_ok
//   MEM_DRAIN | flushed while outstanding; data_ok is swallowed
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic        flush_i,
   input  logic [31:0] pc_i,
   input  logic [7:0]  aluop_i,
   input  logic        now_in_delayslot_i,
   input  logic [31:0] exception_type_i,
   input  logic [31:0] alu_data_i,
   input  logic [31:0] ram_write_data_i,
   input  logic        mem_to_reg_i,
   input  logic        regfile_write_enable_i,
   input  logic [4:0]  regfile_write_addr_i,
   input  logic        hi_write_enable_i,
   input  logic [31:0] hi_write_data_i,
   input  logic        lo_write_enable_i,
   input  logic [31:0] lo_write_data_i,
   input  logic        cp0_write_enable_i,
   input  logic [4:0]  cp0_write_addr_i,
   input  logic [31:0] cp0_write_data_i,
   output logic        data_req_o,
   output logic        data_wr_o,
   output logic [1:0]  data_size_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   output logic [3:0]  data_wstrb_o,
   input  logic        data_addr_ok_i,
   input  logic        data_data_ok_i,
   input  logic [31:0] data_rdata_i,
   output logic        mem_stall_request_o,
   output logic [31:0] bad_vaddr_o,
   output logic        wb_valid_o,
   output logic [31:0] wb_pc_o,
   output logic [7:0]  wb_aluop_o,
   output logic        wb_now_in_delayslot_o,
   output logic [31:0] wb_exception_type_o,
   output logic        wb_regfile_write_enable_o,
   output logic [4:0]  wb_regfile_write_addr_o,
   output logic [31:0] wb_regfile_write_data_o,
   output logic        wb_hi_write_enable_o,
   output logic [31:0] wb_hi_write_data_o,
   output logic        wb_lo_write_enable_o,
   output logic [31:0] wb_lo_write_data_o,
   output logic        wb_cp0_write_enable_o,
   output logic [4:0]  wb_cp0_write_addr_o,
   output logic [31:0] wb_cp0_write_data_o
);

   mem_state_e  state_q, state_d;
   wb_t         wb_q, wb_d;
   logic        is_ld, is_st, addr_err, mem_op, commit_ok;
   logic        req, stall, load_done;
   logic [31:0] exc_out, load_data, st_wdata;
   logic [3:0]  st_wstrb;
   logic [1:0]  st_size;

   mem_align u_align (
      .aluop_i      (aluop_i),
      .addr_lo_i    (alu_data_i[1:0]),
      .rdata_i      (data_rdata_i),
      .store_data_i (ram_write_data_i),
      .load_data_o  (load_data),
      .wdata_o      (st_wdata),
      .wstrb_o      (st_wstrb),
      .size_o       (st_size)
   );

   assign is_ld    = is_load(aluop_i);
   assign is_st    = is_store(aluop_i);
   assign addr_err = valid_i & (is_ld | is_st) & misaligned(aluop_i, alu_data_i[1:0]);

   always_comb begin
      exc_out = exception_type_i;
      if (addr_err) begin
         if (is_ld) exc_out[EXC_ADEL] = 1'b1;
         else       exc_out[EXC_ADES] = 1'b1;
      end
   end

   assign mem_op    = valid_i & (is_ld | is_st) & ~|exc_out;
   assign commit_ok = valid_i & ~|exc_out;
   assign load_done = (state_q == MEM_DATA) & data_data_ok_i;

   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      stall   = 1'b0;
      case (state_q)
         MEM_IDLE: begin
            if (mem_op && !flush_i) begin
               req     = 1'b1;
               stall   = 1'b1;
               state_d = data_addr_ok_i ? MEM_DATA : MEM_ADDR;
            end
         end
         MEM_ADDR: begin
            stall = 1'b1;
            if (flush_i) begin
               state_d = MEM_IDLE;
            end else begin
               req = 1'b1;
               if (data_addr_ok_i) state_d = MEM_DATA;
            end
         end
         MEM_DATA: begin
            stall = ~data_data_ok_i;
            if (data_data_ok_i) state_d = MEM_IDLE;
            else if (flush_i)   state_d = MEM_DRAIN;
         end
         MEM_DRAIN: begin
            stall = 1'b1;
            if (data_data_ok_i) state_d = MEM_IDLE;
         end
         default: state_d = MEM_IDLE;
      endcase
      // Reset is synchronous, so keep the combinational outputs quiet during it too.
      if (rst) begin
         req   = 1'b0;
         stall = 1'b0;
      end
   end

   always_comb begin
      wb_d = '0;
      if (!stall && !flush_i) begin
         wb_d.valid     = valid_i;
         wb_d.pc        = pc_i;
         wb_d.aluop     = aluop_i;
         wb_d.in_dslot  = now_in_delayslot_i;
         wb_d.exc       = exc_out;
         wb_d.rf_we     = commit_ok & regfile_write_enable_i;
         wb_d.rf_waddr  = regfile_write_addr_i;
         wb_d.rf_wdata  = (load_done && mem_to_reg_i) ? load_data : alu_data_i;
         wb_d.hi_we     = commit_ok & hi_write_enable_i;
         wb_d.hi_wdata  = hi_write_data_i;
         wb_d.lo_we     = commit_ok & lo_write_enable_i;
         wb_d.lo_wdata  = lo_write_data_i;
         wb_d.cp0_we    = commit_ok & cp0_write_enable_i;
         wb_d.cp0_waddr = cp0_write_addr_i;
         wb_d.cp0_wdata = cp0_write_data_i;
         wb_d.bad_vaddr = addr_err ? alu_data_i : 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MEM_IDLE;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         wb_q    <= wb_d;
      end
   end

   assign data_req_o          = req;
   assign data_wr_o           = req & is_st;
   assign data_size_o         = req ? st_size : 2'd0;
   assign data_addr_o         = req ? alu_data_i : 32'h0;
   assign data_wdata_o        = (req && is_st) ? st_wdata : 32'h0;
   assign data_wstrb_o        = req ? st_wstrb : 4'b0000;
   assign mem_stall_request_o = stall;

   assign bad_vaddr_o               = wb_q.bad_vaddr;
   assign wb_valid_o                = wb_q.valid;
   assign wb_pc_o                   = wb_q.pc;
   assign wb_aluop_o                = wb_q.aluop;
   assign wb_now_in_delayslot_o     = wb_q.in_dslot;
   assign wb_exception_type_o       = wb_q.exc;
   assign wb_regfile_write_enable_o = wb_q.rf_we;
   assign wb_regfile_write_addr_o   = wb_q.rf_waddr;
   assign wb_regfile_write_data_o   = wb_q.rf_wdata;
   assign wb_hi_write_enable_o      = wb_q.hi_we;
   assign wb_hi_write_data_o        = wb_q.hi_wdata;
   assign wb_lo_write_enable_o      = wb_q.lo_we;
   assign wb_lo_write_data_o        = wb_q.lo_wdata;
   assign wb_cp0_write_enable_o     = wb_q.cp0_we;
   assign wb_cp0_write_addr_o       = wb_q.cp0_waddr;
   assign wb_cp0_write_data_o       = wb_q.cp0_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: expected WB results go into a queue when an
// instruction is driven and are compared by a monitor when wb_valid_o appears.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk, rst, valid_i, flush_i, now_in_delayslot_i, mem_to_reg_i;
   logic [31:0] pc_i, exception_type_i, alu_data_i, ram_write_data_i;
   logic [7:0]  aluop_i;
   logic        regfile_write_enable_i, hi_write_enable_i, lo_write_enable_i, cp0_write_enable_i;
   logic [4:0]  regfile_write_addr_i, cp0_write_addr_i;
   logic [31:0] hi_write_data_i, lo_write_data_i, cp0_write_data_i;
   logic        data_req_o, data_wr_o;
   logic [1:0]  data_size_o;
   logic [31:0] data_addr_o, data_wdata_o;
   logic [3:0]  data_wstrb_o;
   logic        data_addr_ok_i, data_data_ok_i;
   logic [31:0] data_rdata_i;
   logic        mem_stall_request_o;
   logic [31:0] bad_vaddr_o;
   logic        wb_valid_o, wb_now_in_delayslot_o;
   logic [31:0] wb_pc_o, wb_exception_type_o, wb_regfile_write_data_o;
   logic [7:0]  wb_aluop_o;
   logic        wb_regfile_write_enable_o, wb_hi_write_enable_o, wb_lo_write_enable_o, wb_cp0_write_enable_o;
   logic [4:0]  wb_regfile_write_addr_o, wb_cp0_write_addr_o;
   logic [31:0] wb_hi_write_data_o, wb_lo_write_data_o, wb_cp0_write_data_o;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      logic        we;
      logic [31:0] exc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   tests_run    = 0;
   int   tests_failed = 0;

   mem_stage dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i),
      .pc_i(pc_i), .aluop_i(aluop_i), .now_in_delayslot_i(now_in_delayslot_i),
      .exception_type_i(exception_type_i), .alu_data_i(alu_data_i),
      .ram_write_data_i(ram_write_data_i), .mem_to_reg_i(mem_to_reg_i),
      .regfile_write_enable_i(regfile_write_enable_i), .regfile_write_addr_i(regfile_write_addr_i),
      .hi_write_enable_i(hi_write_enable_i), .hi_write_data_i(hi_write_data_i),
      .lo_write_enable_i(lo_write_enable_i), .lo_write_data_i(lo_write_data_i),
      .cp0_write_enable_i(cp0_write_enable_i), .cp0_write_addr_i(cp0_write_addr_i),
      .cp0_write_data_i(cp0_write_data_i),
      .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
      .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_wstrb_o(data_wstrb_o),
      .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i), .data_rdata_i(data_rdata_i),
      .mem_stall_request_o(mem_stall_request_o), .bad_vaddr_o(bad_vaddr_o),
      .wb_valid_o(wb_valid_o), .wb_pc_o(wb_pc_o), .wb_aluop_o(wb_aluop_o),
      .wb_now_in_delayslot_o(wb_now_in_delayslot_o), .wb_exception_type_o(wb_exception_type_o),
      .wb_regfile_write_enable_o(wb_regfile_write_enable_o),
      .wb_regfile_write_addr_o(wb_regfile_write_addr_o),
      .wb_regfile_write_data_o(wb_regfile_write_data_o),
      .wb_hi_write_enable_o(wb_hi_write_enable_o), .wb_hi_write_data_o(wb_hi_write_data_o),
      .wb_lo_write_enable_o(wb_lo_write_enable_o), .wb_lo_write_data_o(wb_lo_write_data_o),
      .wb_cp0_write_enable_o(wb_cp0_write_enable_o), .wb_cp0_write_addr_o(wb_cp0_write_addr_o),
      .wb_cp0_write_data_o(wb_cp0_write_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard: every valid WB entry must match the oldest expectation.
   always @(negedge clk) begin
      if (wb_valid_o === 1'b1) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL wb_unexpected: got pc=%h data=%h, expected no valid WB entry",
                     wb_pc_o, wb_regfile_write_data_o);
         end else begin
            mon_e = exp_q.pop_front();
            if (wb_pc_o !== mon_e.pc || wb_regfile_write_data_o !== mon_e.data ||
                wb_regfile_write_enable_o !== mon_e.we || wb_exception_type_o !== mon_e.exc) begin
               tests_failed++;
               $display("FAIL wb_result: got pc=%h data=%h we=%b exc=%h, expected pc=%h data=%h we=%b exc=%h",
                        wb_pc_o, wb_regfile_write_data_o, wb_regfile_write_enable_o, wb_exception_type_o,
                        mon_e.pc, mon_e.data, mon_e.we, mon_e.exc);
            end
         end
      end
   end

   task automatic clear_instr();
      valid_i = 1'b0; flush_i = 1'b0; pc_i = 32'h0; aluop_i = 8'h0; now_in_delayslot_i = 1'b0;
      exception_type_i = 32'h0; alu_data_i = 32'h0; ram_write_data_i = 32'h0; mem_to_reg_i = 1'b0;
      regfile_write_enable_i = 1'b0; regfile_write_addr_i = 5'd0;
      hi_write_enable_i = 1'b0; hi_write_data_i = 32'h0; lo_write_enable_i = 1'b0; lo_write_data_i = 32'h0;
      cp0_write_enable_i = 1'b0; cp0_write_addr_i = 5'd0; cp0_write_data_i = 32'h0;
      data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = 32'h0;
   endtask

   task automatic drive_instr(input logic [31:0] pc, input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] rt, input logic ld, input logic we);
      valid_i = 1'b1; pc_i = pc; aluop_i = op; alu_data_i = addr; ram_write_data_i = rt;
      mem_to_reg_i = ld; regfile_write_enable_i = we; regfile_write_addr_i = 5'd3;
      exception_type_i = 32'h0;
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] data, input logic we,
                           input logic [31:0] exc);
      exp_t e;
      e.pc = pc; e.data = data; e.we = we; e.exc = exc;
      exp_q.push_back(e);
   endtask

   // Bus slave: addr_ok in cycle a, data_ok in cycle a+d, optional flush pulse in cycle f.
   task automatic bus_cycle(input int a, input int d, input int f, input logic [31:0] rdata,
                            output int stalls, output int reqs, output logic changed,
                            output logic [31:0] r_addr, output logic [31:0] r_wdata,
                            output logic [3:0] r_wstrb, output logic [1:0] r_size,
                            output logic r_wr, output logic tail_stall);
      stalls = 0; reqs = 0; changed = 1'b0;
      r_addr = 32'h0; r_wdata = 32'h0; r_wstrb = 4'h0; r_size = 2'd0; r_wr = 1'b0;
      for (int c = 0; c <= a + d && c < 40; c++) begin
         data_addr_ok_i = (c == a);
         data_data_ok_i = (c == a + d);
         data_rdata_i   = (c == a + d) ? rdata : 32'h0;
         flush_i        = (c == f);
         if (f >= 0 && c > f) valid_i = 1'b0;
         @(negedge clk);
         if (mem_stall_request_o === 1'b1) stalls++;
         if (data_req_o === 1'b1) begin
            if (reqs == 0) begin
               r_addr = data_addr_o; r_wdata = data_wdata_o; r_wstrb = data_wstrb_o;
               r_size = data_size_o; r_wr = data_wr_o;
            end else if (data_addr_o !== r_addr || data_wdata_o !== r_wdata ||
                         data_wstrb_o !== r_wstrb || data_size_o !== r_size) begin
               changed = 1'b1;
            end
            reqs++;
         end
         @(posedge clk); #1;
      end
      clear_instr();
      @(negedge clk);
      tail_stall = mem_stall_request_o;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      clear_instr();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      tests_run++;
      if (data_req_o !== 1'b0 || mem_stall_request_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got req=%b stall=%b, expected 0 0", data_req_o, mem_stall_request_o);
      end
      tests_run++;
      if (wb_valid_o !== 1'b0 || wb_pc_o !== 32'h0 || wb_regfile_write_data_o !== 32'h0 ||
          wb_exception_type_o !== 32'h0 || bad_vaddr_o !== 32'h0 || data_addr_o !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got valid=%b pc=%h data=%h exc=%h bva=%h addr=%h, expected all 0",
                  wb_valid_o, wb_pc_o, wb_regfile_write_data_o, wb_exception_type_o, bad_vaddr_o, data_addr_o);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_alu();
      drive_instr(32'h100, ALUOP_ADDU, 32'h12345678, 32'h0, 1'b0, 1'b1);
      hi_write_enable_i = 1'b1; hi_write_data_i = 32'h0000BEEF;
      push_exp(32'h100, 32'h12345678, 1'b1, 32'h0);
      @(negedge clk);
      tests_run++;
      if (mem_stall_request_o !== 1'b0 || data_req_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL alu_no_stall: got stall=%b req=%b, expected 0 0", mem_stall_request_o, data_req_o);
      end
      @(posedge clk); #1;
      // Same ALU op but with an incoming exception: every write enable must drop.
      drive_instr(32'h104, ALUOP_ADDU, 32'h00000042, 32'h0, 1'b0, 1'b1);
      exception_type_i = 32'h0000_0100;
      hi_write_enable_i = 1'b1;
      push_exp(32'h104, 32'h00000042, 1'b0, 32'h0000_0100);
      @(negedge clk);
      tests_run++;
      if (wb_hi_write_enable_o !== 1'b1 || wb_hi_write_data_o !== 32'h0000BEEF) begin
         tests_failed++;
         $display("FAIL alu_hi_write: got we=%b data=%h, expected 1 0000beef",
                  wb_hi_write_enable_o, wb_hi_write_data_o);
      end
      @(posedge clk); #1;
      clear_instr();
      @(negedge clk);
      tests_run++;
      if (wb_hi_write_enable_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL exc_hi_forced: got we=%b, expected 0", wb_hi_write_enable_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_load_byte();
      int st, rq; logic ch, wr, tl; logic [31:0] ad, wd; logic [3:0] sb; logic [1:0] sz;
      drive_instr(32'h200, ALUOP_LB, 32'h1003, 32'h0, 1'b1, 1'b1);
      push_exp(32'h200, 32'hFFFFFF80, 1'b1, 32'h0);
      bus_cycle(0, 3, -1, 32'h80FFFFFF, st, rq, ch, ad, wd, sb, sz, wr, tl);
      tests_run++;
      if (st != 3 || rq != 1 || tl !== 1'b0) begin
         tests_failed++;
         $display("FAIL lb_stall: got stalls=%0d reqs=%0d tail=%b, expected 3 1 0", st, rq, tl);
      end
      tests_run++;
      if (ad !== 32'h1003 || wr !== 1'b0 || sz !== SIZE_BYTE) begin
         tests_failed++;
         $display("FAIL lb_bus: got addr=%h wr=%b size=%0d, expected 00001003 0 0", ad, wr, sz);
      end
   endtask

   task automatic test_store_half();
      int st, rq; logic ch, wr, tl; logic [31:0] ad, wd; logic [3:0] sb; logic [1:0] sz;
      drive_instr(32'h300, ALUOP_SH, 32'h2002, 32'h0000ABCD, 1'b0, 1'b0);
      push_exp(32'h300, 32'h2002, 1'b0, 32'h0);
      bus_cycle(2, 1, -1, 32'h0, st, rq, ch, ad, wd, sb, sz, wr, tl);
      tests_run++;
      if (rq != 3 || ch !== 1'b0 || st != 3) begin
         tests_failed++;
         $display("FAIL sh_hold: got reqs=%0d changed=%b stalls=%0d, expected 3 0 3", rq, ch, st);
      end
      tests_run++;
      if (sb !== 4'b1100 || wd !== 32'hABCDABCD || sz !== SIZE_HALF || wr !== 1'b1 || ad !== 32'h2002) begin
         tests_failed++;
         $display("FAIL sh_bus: got wstrb=%b wdata=%h size=%0d wr=%b addr=%h, expected 1100 abcdabcd 1 1 00002002",
                  sb, wd, sz, wr, ad);
      end
   endtask

   task automatic test_loads_stores();
      int st, rq; logic ch, wr, tl; logic [31:0] ad, wd; logic [3:0] sb; logic [1:0] sz;
      logic [7:0] op; logic [31:0] addr, rt, rdata, exp_d, exp_wd; logic [3:0] exp_sb;
      logic [1:0] exp_sz; logic ld;
      for (int i = 0; i < 7; i++) begin
         rt = 32'h0; rdata = 32'h0; exp_wd = 32'h0; exp_sb = 4'h0;
         case (i)
            0: begin op = ALUOP_LBU; addr = 32'h5001; rdata = 32'h11228033; exp_d = 32'h00000080; exp_sz = SIZE_BYTE; end
            1: begin op = ALUOP_LH;  addr = 32'h5002; rdata = 32'h80017FFF; exp_d = 32'hFFFF8001; exp_sz = SIZE_HALF; end
            2: begin op = ALUOP_LHU; addr = 32'h5000; rdata = 32'h12349ABC; exp_d = 32'h00009ABC; exp_sz = SIZE_HALF; end
            3: begin op = ALUOP_LW;  addr = 32'h5004; rdata = 32'hCAFEF00D; exp_d = 32'hCAFEF00D; exp_sz = SIZE_WORD; end
            4: begin op = ALUOP_SB;  addr = 32'h6002; rt = 32'h000000A5; exp_d = 32'h6002;
                      exp_wd = 32'hA5A5A5A5; exp_sb = 4'b0100; exp_sz = SIZE_BYTE; end
            5: begin op = ALUOP_SW;  addr = 32'h6004; rt = 32'h13579BDF; exp_d = 32'h6004;
                      exp_wd = 32'h13579BDF; exp_sb = 4'b1111; exp_sz = SIZE_WORD; end
            default: begin op = ALUOP_LB; addr = 32'h5000; rdata = 32'h0000007F; exp_d = 32'h0000007F; exp_sz = SIZE_BYTE; end
         endcase
         ld = is_load(op);
         drive_instr(32'h1000 + 32'(i) * 4, op, addr, rt, ld, ld);
         push_exp(32'h1000 + 32'(i) * 4, exp_d, ld, 32'h0);
         bus_cycle(0, 1, -1, rdata, st, rq, ch, ad, wd, sb, sz, wr, tl);
         tests_run++;
         if (st != 1 || rq != 1 || sz !== exp_sz || wr !== !ld || ad !== addr ||
             (!ld && (sb !== exp_sb || wd !== exp_wd))) begin
            tests_failed++;
            $display("FAIL mem_op_%0d: got stalls=%0d reqs=%0d size=%0d wr=%b addr=%h wstrb=%b wdata=%h, expected 1 1 %0d %b %h %b %h",
                     i, st, rq, sz, wr, ad, sb, wd, exp_sz, !ld, addr, exp_sb, exp_wd);
         end
      end
   endtask

   task automatic test_addr_error();
      logic [7:0] op; logic [31:0] addr, exc; logic ld;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: begin op = ALUOP_LW; addr = 32'h3001; exc = 32'h1000_0000; end
            1: begin op = ALUOP_SH; addr = 32'h2001; exc = 32'h0800_0000; end
            default: begin op = ALUOP_LH; addr = 32'h2003; exc = 32'h1000_0000; end
         endcase
         ld = is_load(op);
         drive_instr(32'h400 + 32'(i) * 4, op, addr, 32'h55, ld, 1'b1);
         push_exp(32'h400 + 32'(i) * 4, addr, 1'b0, exc);
         @(negedge clk);
         tests_run++;
         if (data_req_o !== 1'b0 || mem_stall_request_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL adderr_req_%0d: got req=%b stall=%b, expected 0 0", i, data_req_o, mem_stall_request_o);
         end
         @(posedge clk); #1;
         clear_instr();
         @(negedge clk);
         tests_run++;
         if (bad_vaddr_o !== addr) begin
            tests_failed++;
            $display("FAIL adderr_badvaddr_%0d: got %h, expected %h", i, bad_vaddr_o, addr);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_flush_drain();
      int st, rq; logic ch, wr, tl; logic [31:0] ad, wd; logic [3:0] sb; logic [1:0] sz;
      drive_instr(32'h500, ALUOP_LW, 32'h4000, 32'h0, 1'b1, 1'b1);
      bus_cycle(0, 3, 1, 32'h11111111, st, rq, ch, ad, wd, sb, sz, wr, tl);
      tests_run++;
      if (st != 4 || rq != 1 || tl !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_drain: got stalls=%0d reqs=%0d tail=%b, expected 4 1 0", st, rq, tl);
      end
      drive_instr(32'h504, ALUOP_LW, 32'h4004, 32'h0, 1'b1, 1'b1);
      push_exp(32'h504, 32'hDEADBEEF, 1'b1, 32'h0);
      bus_cycle(0, 1, -1, 32'hDEADBEEF, st, rq, ch, ad, wd, sb, sz, wr, tl);
      tests_run++;
      if (st != 1 || rq != 1 || ad !== 32'h4004) begin
         tests_failed++;
         $display("FAIL after_drain: got stalls=%0d reqs=%0d addr=%h, expected 1 1 00004004", st, rq, ad);
      end
   endtask

   task automatic test_reset_mid();
      int st, rq; logic ch, wr, tl; logic [31:0] ad, wd; logic [3:0] sb; logic [1:0] sz;
      drive_instr(32'h600, ALUOP_SH, 32'h7000, 32'h1234, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if (data_req_o !== 1'b1 || mem_stall_request_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL addr_wait: got req=%b stall=%b, expected 1 1", data_req_o, mem_stall_request_o);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      clear_instr();
      @(negedge clk);
      tests_run++;
      if (data_req_o !== 1'b0 || mem_stall_request_o !== 1'b0 || wb_valid_o !== 1'b0 ||
          wb_pc_o !== 32'h0 || bad_vaddr_o !== 32'h0 || data_addr_o !== 32'h0 || data_wstrb_o !== 4'h0) begin
         tests_failed++;
         $display("FAIL reset_mid: got req=%b stall=%b valid=%b pc=%h bva=%h addr=%h wstrb=%b, expected all 0",
                  data_req_o, mem_stall_request_o, wb_valid_o, wb_pc_o, bad_vaddr_o, data_addr_o, data_wstrb_o);
      end
      @(posedge clk); #1;
      drive_instr(32'h604, ALUOP_LW, 32'h7004, 32'h0, 1'b1, 1'b1);
      push_exp(32'h604, 32'h0BADF00D, 1'b1, 32'h0);
      bus_cycle(0, 1, -1, 32'h0BADF00D, st, rq, ch, ad, wd, sb, sz, wr, tl);
      tests_run++;
      if (st != 1 || rq != 1) begin
         tests_failed++;
         $display("FAIL reset_recover: got stalls=%0d reqs=%0d, expected 1 1", st, rq);
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_instr();
      test_reset();
      test_alu();
      test_load_byte();
      test_store_half();
      test_loads_stores();
      test_addr_error();
      test_flush_drain();
      test_reset_mid();
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL wb_missing: got %0d results still pending, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
